// File: rtl/arb_pkg.sv
// Shared types for the two-requester round-robin arbiter:
// FSM state encoding and one-hot grant codes.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G1   = 2'd1,
    G2   = 2'd2
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I1   = 2'b01;
  localparam logic [1:0] GNT_I2   = 2'b10;

  function automatic logic [1:0] gnt_of(state_e s);
    unique case (s)
      G1:      return GNT_I1;
      G2:      return GNT_I2;
      default: return GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_mux2_w.sv
// Purely combinational 2:1 select of WIDTH data bits plus last flag.
// s_i=0 picks a_i, s_i=1 picks b_i.
module mux2_w #(
  parameter int WIDTH = 8
) (
  input  logic             s_i,
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH:0]   b_i,
  output logic [WIDTH:0]   y_o
);

  assign y_o = ({(WIDTH+1){~s_i}} & a_i)
             | ({(WIDTH+1){ s_i}} & b_i);

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin burst arbiter sharing one 2:1 mux between two
// valid/ready requesters, feeding a one-entry output register.
module mux2_rr_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             I1_valid,
  input  logic [WIDTH-1:0] I1_data,
  input  logic             I1_last,
  output logic             I1_ready,
  input  logic             I2_valid,
  input  logic [WIDTH-1:0] I2_data,
  input  logic             I2_last,
  output logic             I2_ready,
  output logic             Y_valid,
  output logic [WIDTH-1:0] Y_data,
  output logic             Y_last,
  input  logic             Y_ready,
  output logic [1:0]       gnt
);

  state_e           state_q;
  logic             prio_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  logic             y_valid_q, y_valid_d;
  logic [WIDTH-1:0] y_data_q, y_data_d;
  logic             y_last_q, y_last_d;

  logic             sel;
  logic             space;
  logic             in_valid;
  logic             acc;
  logic             rel;
  logic [WIDTH:0]   mux_y;

  assign sel = (state_q == G2);

  mux2_w #(.WIDTH(WIDTH)) u_mux (
    .s_i (sel),
    .a_i ({I1_last, I1_data}),
    .b_i ({I2_last, I2_data}),
    .y_o (mux_y)
  );

  assign space    = ~y_valid_q | Y_ready;
  assign in_valid = sel ? I2_valid : I1_valid;
  assign acc      = (state_q != IDLE) & in_valid & space;
  assign cnt_inc  = cnt_q + 1'b1;
  assign rel      = mux_y[WIDTH]
                  | (cnt_inc == CNT_W'(MAX_BURST));

  assign I1_ready = (state_q == G1) & space;
  assign I2_ready = (state_q == G2) & space;
  assign gnt      = gnt_of(state_q);

  // prio_q=1 favours I2 at the next contest
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (I1_valid & (~I2_valid | ~prio_q))
            state_q <= G1;
          else if (I2_valid)
            state_q <= G2;
        end
        G1, G2: begin
          if (acc) begin
            if (rel) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              prio_q  <= (state_q == G1);
            end else begin
              cnt_q   <= cnt_inc;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_last_d  = y_last_q;
    if (acc) begin
      y_valid_d = 1'b1;
      y_data_d  = mux_y[WIDTH-1:0];
      y_last_d  = mux_y[WIDTH];
    end else if (Y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_last_q  <= 1'b0;
    end else begin
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_last_q  <= y_last_d;
    end
  end

  assign Y_valid = y_valid_q;
  assign Y_data  = y_data_q;
  assign Y_last  = y_last_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: producer queues, Y-side scoreboard
// monitor with a burst-level ownership model, directed + random phases.
module tb_mux2_rr_arbiter;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;

  localparam int MAXB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       I1_valid, I1_last, I1_ready;
  logic       I2_valid, I2_last, I2_ready;
  logic [7:0] I1_data, I2_data;
  logic       Y_valid, Y_last, Y_ready;
  logic [7:0] Y_data;
  logic [1:0] gnt;

  logic [1:0] vld;
  beat_t      cur[2];
  logic [1:0] acc_seen;
  int         vprob, yprob;
  logic       stall;

  beat_t src_q[2][$];
  beat_t exp_q[2][$];
  int    burst_src[$];
  int    burst_len[$];
  int    owner, blen, prev_src;
  logic  fair_chk;
  logic  hold_prev;
  beat_t prev_y;

  int checks = 0;
  int failures = 0;

  assign I1_valid = vld[0];
  assign I1_data  = cur[0].data;
  assign I1_last  = cur[0].last;
  assign I2_valid = vld[1];
  assign I2_data  = cur[1].data;
  assign I2_last  = cur[1].last;

  mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(MAXB), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .I1_valid (I1_valid),
    .I1_data  (I1_data),
    .I1_last  (I1_last),
    .I1_ready (I1_ready),
    .I2_valid (I2_valid),
    .I2_data  (I2_data),
    .I2_last  (I2_last),
    .I2_ready (I2_ready),
    .Y_valid  (Y_valid),
    .Y_data   (Y_data),
    .Y_last   (Y_last),
    .Y_ready  (Y_ready),
    .gnt      (gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, expv, $time);
    end
  endtask

  task automatic push(input int s, input logic [7:0] d, input logic l);
    beat_t b;
    b.last = l;
    b.data = d;
    src_q[s].push_back(b);
    exp_q[s].push_back(b);
  endtask

  task automatic nb();
    @(negedge clk);
    #2;
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || Y_valid)
           && c < maxc) begin
      nb();
      c++;
    end
    chk("drain_timeout", c >= maxc, 0);
  endtask

  // producers: hold a presented beat until it is taken
  always @(posedge clk) begin
    #1;
    for (int s = 0; s < 2; s++) begin
      if (acc_seen[s] && src_q[s].size() > 0)
        void'(src_q[s].pop_front());
      if (src_q[s].size() == 0)
        vld[s] = 1'b0;
      else if (!vld[s] || acc_seen[s])
        vld[s] = ($urandom_range(99) < vprob);
      cur[s] = (src_q[s].size() > 0) ? src_q[s][0] : '0;
    end
    Y_ready = !stall && ($urandom_range(99) < yprob);
  end

  // monitor: burst ownership model and per-requester order
  always @(negedge clk) begin : mon
    beat_t y;
    int s;
    acc_seen[0] = I1_valid & I1_ready;
    acc_seen[1] = I2_valid & I2_ready;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      chk("rdy_gnt", {29'd0, gnt == 2'b11, I1_ready & ~gnt[0],
                      I2_ready & ~gnt[1]}, 0);
      y.last = Y_last;
      y.data = Y_data;
      if (hold_prev && Y_valid)
        chk("y_stable", 32'(y), 32'(prev_y));
      hold_prev = Y_valid & ~Y_ready;
      prev_y = y;
      if (Y_valid && Y_ready) begin
        s = owner;
        if (s < 0) begin
          if (exp_q[0].size() > 0 && exp_q[0][0] == y) s = 0;
          else if (exp_q[1].size() > 0 && exp_q[1][0] == y) s = 1;
          if (s < 0) begin
            chk("y_unexpected", 32'(y), 32'hFFFF_FFFF);
          end else begin
            if (fair_chk && prev_src == s && exp_q[1-s].size() > 0)
              chk("fairness", s, 1 - s);
            owner = s;
            blen = 0;
          end
        end
        if (s >= 0) begin
          if (exp_q[s].size() == 0) begin
            chk("y_extra", 32'(y), 32'hFFFF_FFFF);
          end else begin
            chk("y_beat", 32'(y), 32'(exp_q[s][0]));
            void'(exp_q[s].pop_front());
            blen++;
            if (y.last || blen == MAXB) begin
              burst_src.push_back(s);
              burst_len.push_back(blen);
              prev_src = s;
              owner = -1;
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  logic [3:0] expa[5];
  logic [7:0] expd[5];
  int         nb0, first, c, seq0, seq1, len;
  logic [8:0] cap;

  initial begin
    rst = 1'b1;
    vld = '0;
    cur[0] = '0;
    cur[1] = '0;
    acc_seen = '0;
    Y_ready = 1'b0;
    stall = 1'b0;
    vprob = 100;
    yprob = 100;
    owner = -1;
    prev_src = -1;
    blen = 0;
    fair_chk = 1'b0;
    hold_prev = 1'b0;
    prev_y = '0;
    repeat (3) nb();
    chk("reset_outs", {Y_valid, Y_last, Y_data, gnt, I1_ready, I2_ready}, 0);
    rst = 1'b0;
    nb();

    // single 3-beat burst from I1
    push(0, 8'hAA, 0);
    push(0, 8'hBB, 0);
    push(0, 8'hCC, 1);
    c = 0;
    while (gnt == 2'b00 && c < 20) begin
      nb();
      c++;
    end
    chk("a_gnt_timeout", c >= 20, 0);
    expa = '{4'b0110, 4'b0111, 4'b0111, 4'b0001, 4'b0000};
    expd = '{8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h00};
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("a_ctl%0d", k), {gnt, I1_ready, Y_valid}, expa[k]);
      if (k >= 1 && k <= 3)
        chk($sformatf("a_dat%0d", k), {Y_last, Y_data},
            {k == 3, expd[k]});
      nb();
    end
    drain(200);

    // both saturated with 2-beat bursts: strict alternation
    fair_chk = 1'b1;
    prev_src = -1;
    nb0 = burst_src.size();
    first = 1 - burst_src[nb0-1];
    for (int b = 0; b < 4; b++) begin
      push(0, 8'(8'h10 + 2*b), 0);
      push(0, 8'(8'h11 + 2*b), 1);
      push(1, 8'(8'h90 + 2*b), 0);
      push(1, 8'(8'h91 + 2*b), 1);
    end
    drain(400);
    fair_chk = 1'b0;
    chk("b_nbursts", burst_src.size() - nb0, 8);
    for (int i = 0; i < 8 && nb0 + i < burst_src.size(); i++) begin
      chk($sformatf("b_src%0d", i), burst_src[nb0+i], (first + i) % 2);
      chk($sformatf("b_len%0d", i), burst_len[nb0+i], 2);
    end

    // I2 20-beat burst, last only on beat 20, I1 waiting
    nb0 = burst_src.size();
    for (int i = 0; i < 20; i++)
      push(1, 8'(8'hC0 + i), i == 19);
    c = 0;
    while (gnt != 2'b10 && c < 20) begin
      nb();
      c++;
    end
    chk("c_gnt_timeout", c >= 20, 0);
    push(0, 8'h20, 0);
    push(0, 8'h21, 1);
    drain(400);
    chk("c_nbursts", burst_src.size() - nb0, 3);
    if (burst_src.size() - nb0 == 3) begin
      chk("c_b0", {burst_src[nb0], burst_len[nb0]}, {32'd1, 32'd16});
      chk("c_b1", {burst_src[nb0+1], burst_len[nb0+1]}, {32'd0, 32'd2});
      chk("c_b2", {burst_src[nb0+2], burst_len[nb0+2]}, {32'd1, 32'd4});
    end

    // sink stall of 4 cycles mid-burst
    nb0 = burst_src.size();
    for (int i = 0; i < 8; i++)
      push(0, 8'(8'h30 + i), i == 7);
    c = 0;
    while (!Y_valid && c < 20) begin
      nb();
      c++;
    end
    chk("d_yv_timeout", c >= 20, 0);
    nb();
    stall = 1'b1;
    nb();
    cap = {Y_last, Y_data};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("d_stall%0d", k), {I1_ready, Y_valid}, 2'b01);
      chk($sformatf("d_hold%0d", k), {Y_last, Y_data}, cap);
      if (k < 3) nb();
    end
    stall = 1'b0;
    drain(200);
    chk("d_burst", {burst_src[burst_src.size()-1],
                    burst_len[burst_len.size()-1]}, {32'd0, 32'd8});

    // async reset with a held beat, then first contest
    for (int i = 0; i < 6; i++)
      push(0, 8'(8'h50 + i), i == 5);
    c = 0;
    while (!Y_valid && c < 20) begin
      nb();
      c++;
    end
    stall = 1'b1;
    nb();
    nb();
    rst = 1'b1;
    #1;
    chk("e_rst_outs", {Y_valid, gnt, I1_ready, I2_ready}, 0);
    src_q[0].delete();
    src_q[1].delete();
    exp_q[0].delete();
    exp_q[1].delete();
    acc_seen = '0;
    owner = -1;
    prev_src = -1;
    stall = 1'b0;
    nb0 = burst_src.size();
    push(0, 8'h40, 0);
    push(0, 8'h41, 1);
    push(1, 8'hA0, 0);
    push(1, 8'hA1, 1);
    nb();
    nb();
    rst = 1'b0;
    drain(200);
    chk("e_nbursts", burst_src.size() - nb0, 2);
    if (burst_src.size() > nb0)
      chk("e_first_i1", burst_src[nb0], 0);

    // random valid gaps and sink stalls
    vprob = 60;
    yprob = 70;
    seq0 = 0;
    seq1 = 0;
    for (int b = 0; b < 12; b++) begin
      len = $urandom_range(20, 1);
      for (int i = 0; i < len; i++) begin
        push(0, {1'b0, 7'(seq0)}, i == len - 1);
        seq0++;
      end
      len = $urandom_range(20, 1);
      for (int i = 0; i < len; i++) begin
        push(1, {1'b1, 7'(seq1)}, i == len - 1);
        seq1++;
      end
    end
    drain(5000);
    chk("f_left0", exp_q[0].size(), 0);
    chk("f_left1", exp_q[1].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
